memristor_array_seq: RTL and testbench
======================================

Name: memristor_array_seq

Overview:
- Clocked, parametrised behavioural model of a differential 2-memristor-per-cell crossbar array (ROWS x COLS) with a command/response front end.
- Replaces the latch-based, fixed 64x64 matrix model with timed program and read phases, valid/ready handshakes, and an explicit invalid-cell report.
- Sits between the array sequencer and the readout/accumulate logic.

Parameters:
- ROWS, 64, number of word lines; must be >= 2.
- COLS, 64, number of bit-line columns; must be >= 1.
- PROG_CYCLES, 4, length of the program pulse in clocks; must be >= 1.
- PRECH_CYCLES, 2, length of the read precharge (select-line arm) phase in clocks; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = READ, 1 = PROG.
- cmd_row  in  $clog2(ROWS)  word-line address.
- cmd_col_en  in  COLS  PROG: per-column program enable (ignored for READ).
- cmd_bl  in  COLS  PROG: bit-line level per column.
- cmd_sl  in  COLS  PROG: select-line level per column.
- cmd_din  in  COLS  READ: true data input.
- cmd_dinb  in  COLS  READ: complement data input.
- rsp_valid  out  1  read result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_dout  out  COLS  read result.
- rsp_err  out  1  addressed row was out of range.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset clears every cell to m0 = 0, m1 = 0, so all cells are invalid.
  - Reset values: state IDLE, cmd_ready = 1, rsp_valid = 0, rsp_dout = 0, rsp_err = 0, busy = 0, counter = 0.
- Storage: per cell, a 2-bit register {m1, m0}.
- States: IDLE, PROG, PRECH, SENSE, RESP.
- Command acceptance: a command is accepted on a clock edge where cmd_valid && cmd_ready. All cmd_* fields are registered on that edge.
- IDLE transitions:
  - Accepted PROG -> PROG, counter = PROG_CYCLES - 1.
  - Accepted READ -> PRECH, counter = PRECH_CYCLES - 1.
- PROG:
  - Counter decrements each clock.
  - On the cycle where the counter is 0, each enabled column of the latched row is updated, then the state returns to IDLE.
  - Update by {bl, sl}: 00 -> m1 = 0; 01 -> m0 = 1; 10 -> m0 = 0; 11 -> m1 = 1.
  - Disabled columns are unchanged.
  - A PROG command is not acknowledged on the response channel.
  - Total PROG occupancy is PROG_CYCLES cycles.
- PRECH: counter decrements; at 0 -> SENSE.
- SENSE (exactly one cycle), per column c:
  - If m0 == m1, the cell is invalid and rsp_dout[c] = 0.
  - Otherwise rsp_dout[c] = ~((m0 & din[c]) | (m1 & dinb[c])).
  - Then -> RESP with rsp_valid = 1.
- Read latency: from the accept edge to rsp_valid high is PRECH_CYCLES + 1 clocks.
- RESP:
  - rsp_dout and rsp_err are held stable while rsp_valid && !rsp_ready.
  - On an edge with rsp_ready high -> IDLE and rsp_valid drops.
  - cmd_ready stays low until IDLE, so there is no overlap of command and response.
- Out-of-range row (cmd_row >= ROWS, only possible when ROWS is not a power of two):
  - PROG still takes PROG_CYCLES cycles but changes no cell.
  - READ returns rsp_dout = 0 and rsp_err = 1.
- Reset asserted mid-operation: immediately returns to IDLE with reset values; any in-flight program is lost and array contents are cleared.
- Sequential consistency: a READ following a PROG to the same row sees the programmed values.

Optional Feature:
- Macro: MC_INVALID_MASK_EN.
- When defined:
  - Extra output port rsp_invalid [COLS], registered in SENSE and held with rsp_dout.
  - rsp_invalid[c] = 1 when m0 == m1 for that column; reset value 0.
- When undefined: the port is absent and invalid cells silently read 0.

Decomposition:
- Package mc_array_pkg:
  - State enum mc_state_e.
  - Op encodings MC_OP_READ / MC_OP_PROG.
  - Program codes MC_CLR_M1 = 2'b00, MC_SET_M0 = 2'b01, MC_CLR_M0 = 2'b10, MC_SET_M1 = 2'b11.
- Sub-module mc_cell_row: one row of COLS cells with its storage, program-update logic and combinational sense function.
  - Instantiated ROWS times.
  - Row select is decoded in the top level.

Test Plan:
- Reset, then READ row 0 with din = all 1 -> rsp_valid after PRECH_CYCLES + 1 = 3 clocks; rsp_dout = 0; rsp_invalid = all 1 (when enabled).
- PROG row 5, all columns enabled, {bl, sl} = 01 (set m0) -> busy for 4 cycles; then READ row 5 with din = 0xFFFF..F -> rsp_dout = 0 (m0 = 1 gates din); with din = 0 -> rsp_dout = all 1; rsp_invalid = 0.
- PROG row 7 with code 11 on column 3 only, then READ with dinb[3] = 1, din = 0 -> rsp_dout[3] = 0 (m1 = 1 gates dinb); other columns 0 and invalid.
- Hold rsp_ready low for 10 cycles -> rsp_valid, rsp_dout and rsp_err stable and cmd_ready = 0; a cmd_valid pulse during the stall is not accepted.
- Assert rst_n low during PROG cycle 2 -> outputs at reset values next edge; a READ of that row returns all-invalid.
- ROWS = 48: READ row 50 -> rsp_err = 1, rsp_dout = 0; PROG row 50 changes no cell (row 50 mod 64 aliasing checked on rows 0..47).

Source files
------------

// File: rtl/mc_array_pkg.sv
// Shared types and encodings for the memristor crossbar array model.
package mc_array_pkg;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_PROG  = 3'd1,
    MC_PRECH = 3'd2,
    MC_SENSE = 3'd3,
    MC_RESP  = 3'd4
  } mc_state_e;

  localparam logic MC_OP_READ = 1'b0;
  localparam logic MC_OP_PROG = 1'b1;

  // {bl, sl} program codes
  localparam logic [1:0] MC_CLR_M1 = 2'b00;
  localparam logic [1:0] MC_SET_M0 = 2'b01;
  localparam logic [1:0] MC_CLR_M0 = 2'b10;
  localparam logic [1:0] MC_SET_M1 = 2'b11;

endpackage

// File: rtl/mc_cell_row.sv
// One word line of differential {m1, m0} memristor cells: storage, program update and raw sense.
module mc_cell_row
  import mc_array_pkg::*;
#(
  parameter int unsigned COLS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prog_en,
  input  logic [COLS-1:0] col_en,
  input  logic [COLS-1:0] bl,
  input  logic [COLS-1:0] sl,
  input  logic [COLS-1:0] din,
  input  logic [COLS-1:0] dinb,
  output logic [COLS-1:0] sense_c,
  output logic [COLS-1:0] invalid_c
);

  logic [COLS-1:0] m0;
  logic [COLS-1:0] m1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else if (prog_en) begin
      for (int c = 0; c < COLS; c++) begin
        if (col_en[c]) begin
          case ({bl[c], sl[c]})
            MC_CLR_M1: m1[c] <= 1'b0;
            MC_SET_M0: m0[c] <= 1'b1;
            MC_CLR_M0: m0[c] <= 1'b0;
            default:   m1[c] <= 1'b1;
          endcase
        end
      end
    end
  end

  // Raw sense before invalid masking; the top masks cells where m0 == m1.
  assign sense_c   = ~((m0 & din) | (m1 & dinb));
  assign invalid_c = ~(m0 ^ m1);

endmodule

// File: rtl/memristor_array_seq.sv
// Sequenced ROWS x COLS differential memristor array with command/response handshakes.
// Optional per-column invalid report on rsp_invalid when MC_INVALID_MASK_EN is defined.
module memristor_array_seq
  import mc_array_pkg::*;
#(
  parameter int unsigned ROWS         = 64,
  parameter int unsigned COLS         = 64,
  parameter int unsigned PROG_CYCLES  = 4,
  parameter int unsigned PRECH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [$clog2(ROWS)-1:0]  cmd_row,
  input  logic [COLS-1:0]          cmd_col_en,
  input  logic [COLS-1:0]          cmd_bl,
  input  logic [COLS-1:0]          cmd_sl,
  input  logic [COLS-1:0]          cmd_din,
  input  logic [COLS-1:0]          cmd_dinb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [COLS-1:0]          rsp_dout,
  output logic                     rsp_err,
`ifdef MC_INVALID_MASK_EN
  output logic [COLS-1:0]          rsp_invalid,
`endif
  output logic                     busy
);

  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned MAXC  = (PROG_CYCLES > PRECH_CYCLES) ? PROG_CYCLES : PRECH_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAXC + 1);

  mc_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rsp_valid_nxt, rsp_err_nxt;
  logic [COLS-1:0]  rsp_dout_nxt, inv_nxt;
  logic             accept_c, prog_fire_c, row_oor_c;

  logic [RW-1:0]    row_q;
  logic [COLS-1:0]  col_en_q, bl_q, sl_q, din_q, dinb_q;
  logic [COLS-1:0]  row_sense [ROWS];
  logic [COLS-1:0]  row_inv   [ROWS];
  logic [COLS-1:0]  sel_sense, sel_inv;

  assign accept_c  = (state == MC_IDLE) && cmd_valid;
  assign row_oor_c = ({1'b0, row_q} >= (RW + 1)'(ROWS));

  // Command field capture on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      col_en_q <= '0;
      bl_q     <= '0;
      sl_q     <= '0;
      din_q    <= '0;
      dinb_q   <= '0;
    end else if (accept_c) begin
      row_q    <= cmd_row;
      col_en_q <= cmd_col_en;
      bl_q     <= cmd_bl;
      sl_q     <= cmd_sl;
      din_q    <= cmd_din;
      dinb_q   <= cmd_dinb;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    mc_cell_row #(.COLS(COLS)) u_row (
      .clk       (clk),
      .rst_n     (rst_n),
      .prog_en   (prog_fire_c && (row_q == RW'(r))),
      .col_en    (col_en_q),
      .bl        (bl_q),
      .sl        (sl_q),
      .din       (din_q),
      .dinb      (dinb_q),
      .sense_c   (row_sense[r]),
      .invalid_c (row_inv[r])
    );
  end

  // Row readout mux; an out-of-range row selects nothing and reads as all-invalid
  always_comb begin
    sel_sense = '0;
    sel_inv   = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_q == RW'(r)) begin
        sel_sense = row_sense[r];
        sel_inv   = row_inv[r];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rsp_valid_nxt = rsp_valid;
    rsp_dout_nxt  = rsp_dout;
    rsp_err_nxt   = rsp_err;
`ifdef MC_INVALID_MASK_EN
    inv_nxt       = rsp_invalid;
`else
    inv_nxt       = '0;
`endif
    prog_fire_c   = 1'b0;
    case (state)
      MC_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == MC_OP_PROG) begin
            state_nxt = MC_PROG;
            cnt_nxt   = CNT_W'(PROG_CYCLES - 1);
          end else begin
            state_nxt = MC_PRECH;
            cnt_nxt   = CNT_W'(PRECH_CYCLES - 1);
          end
        end
      end
      MC_PROG: begin
        if (cnt == '0) begin
          prog_fire_c = 1'b1;
          state_nxt   = MC_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      MC_PRECH: begin
        if (cnt == '0) state_nxt = MC_SENSE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      MC_SENSE: begin
        state_nxt     = MC_RESP;
        rsp_valid_nxt = 1'b1;
        rsp_dout_nxt  = sel_sense & ~sel_inv;
        rsp_err_nxt   = row_oor_c;
        inv_nxt       = sel_inv;
      end
      MC_RESP: begin
        if (rsp_ready) begin
          state_nxt     = MC_IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MC_IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dout  <= '0;
      rsp_err   <= 1'b0;
`ifdef MC_INVALID_MASK_EN
      rsp_invalid <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_ready <= (state_nxt == MC_IDLE);
      busy      <= (state_nxt != MC_IDLE);
      rsp_valid <= rsp_valid_nxt;
      rsp_dout  <= rsp_dout_nxt;
      rsp_err   <= rsp_err_nxt;
`ifdef MC_INVALID_MASK_EN
      rsp_invalid <= inv_nxt;
`endif
    end
  end

`ifndef MC_INVALID_MASK_EN
  logic unused_inv;
  assign unused_inv = ^inv_nxt;
`endif

endmodule

// File: tb/tb_memristor_array_seq.sv
// Randomized self-checking bench for memristor_array_seq against a per-cell array model.
module tb_memristor_array_seq;

  localparam int unsigned ROWS         = 48;
  localparam int unsigned COLS         = 16;
  localparam int unsigned PROG_CYCLES  = 4;
  localparam int unsigned PRECH_CYCLES = 2;
  localparam int unsigned RW           = $clog2(ROWS);

  logic            clk, rst_n;
  logic            cmd_valid, cmd_ready, cmd_op;
  logic [RW-1:0]   cmd_row;
  logic [COLS-1:0] cmd_col_en, cmd_bl, cmd_sl, cmd_din, cmd_dinb;
  logic            rsp_valid, rsp_ready, rsp_err, busy;
  logic [COLS-1:0] rsp_dout;
`ifdef MC_INVALID_MASK_EN
  logic [COLS-1:0] rsp_invalid;
`endif

  memristor_array_seq #(
    .ROWS(ROWS), .COLS(COLS), .PROG_CYCLES(PROG_CYCLES), .PRECH_CYCLES(PRECH_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_row    (cmd_row),
    .cmd_col_en (cmd_col_en),
    .cmd_bl     (cmd_bl),
    .cmd_sl     (cmd_sl),
    .cmd_din    (cmd_din),
    .cmd_dinb   (cmd_dinb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dout   (rsp_dout),
    .rsp_err    (rsp_err),
`ifdef MC_INVALID_MASK_EN
    .rsp_invalid(rsp_invalid),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one bit per memristor
  logic [COLS-1:0] mm0 [ROWS];
  logic [COLS-1:0] mm1 [ROWS];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [COLS-1:0] model_read(input int row, input logic [COLS-1:0] din,
                                                 input logic [COLS-1:0] dinb);
    logic [COLS-1:0] r;
    r = '0;
    if (row < ROWS)
      for (int c = 0; c < COLS; c++)
        if (mm0[row][c] != mm1[row][c])
          r[c] = !((mm0[row][c] && din[c]) || (mm1[row][c] && dinb[c]));
    return r;
  endfunction

  function automatic logic [COLS-1:0] model_inv(input int row);
    logic [COLS-1:0] r;
    r = '1;
    if (row < ROWS)
      for (int c = 0; c < COLS; c++) r[c] = (mm0[row][c] == mm1[row][c]);
    return r;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) begin
      mm0[r] = '0;
      mm1[r] = '0;
    end
  endtask

  task automatic model_prog(input int row, input logic [COLS-1:0] en, input logic [COLS-1:0] bl,
                            input logic [COLS-1:0] sl);
    if (row >= ROWS) return;
    for (int c = 0; c < COLS; c++) begin
      if (en[c]) begin
        if (!bl[c] && !sl[c]) mm1[row][c] = 1'b0;
        if (!bl[c] &&  sl[c]) mm0[row][c] = 1'b1;
        if ( bl[c] && !sl[c]) mm0[row][c] = 1'b0;
        if ( bl[c] &&  sl[c]) mm1[row][c] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'(1));
  endtask

  task automatic issue(input logic op, input int row, input logic [COLS-1:0] en,
                       input logic [COLS-1:0] bl, input logic [COLS-1:0] sl,
                       input logic [COLS-1:0] din, input logic [COLS-1:0] dinb);
    wait_ready();
    cmd_op     = op;
    cmd_row    = RW'(row);
    cmd_col_en = en;
    cmd_bl     = bl;
    cmd_sl     = sl;
    cmd_din    = din;
    cmd_dinb   = dinb;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic do_prog(input int row, input logic [COLS-1:0] en, input logic [COLS-1:0] bl,
                         input logic [COLS-1:0] sl);
    int n = 0;
    issue(1'b1, row, en, bl, sl, '0, '0);
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("prog_busy_cycles", 64'(n), 64'(PROG_CYCLES));
    model_prog(row, en, bl, sl);
  endtask

  task automatic do_read(input int row, input logic [COLS-1:0] din, input logic [COLS-1:0] dinb,
                         input int stall, input bit poke);
    int n = 0;
    logic [COLS-1:0] exp;
    issue(1'b0, row, '0, '0, '0, din, dinb);
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("read_latency", 64'(n), 64'(PRECH_CYCLES + 1));
    exp = model_read(row, din, dinb);
    chk("read_dout", 64'(rsp_dout), 64'(exp));
    chk("read_err", 64'(rsp_err), 64'(row >= ROWS));
`ifdef MC_INVALID_MASK_EN
    chk("read_invalid", 64'(rsp_invalid), 64'(model_inv(row)));
`endif
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 2) begin
        cmd_op = 1'b1; cmd_row = RW'(row);
        cmd_col_en = '1; cmd_bl = '1; cmd_sl = '1; cmd_valid = 1'b1;
      end
      tick();
      cmd_valid = 1'b0;
      chk("stall_valid", 64'(rsp_valid), 64'(1));
      chk("stall_dout", 64'(rsp_dout), 64'(exp));
      chk("stall_err", 64'(rsp_err), 64'(row >= ROWS));
      chk("stall_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'(0));
    chk("ready_after_rsp", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    logic [COLS-1:0] en, bl, sl, din, dinb;
    int row;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_row = '0;
    cmd_col_en = '0; cmd_bl = '0; cmd_sl = '0; cmd_din = '0; cmd_dinb = '0;
    rsp_ready = 1'b0;
    model_clear();
    repeat (2) tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_dout", 64'(rsp_dout), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Directed cases
    do_read(0, '1, '0, 0, 0);
    do_prog(5, '1, '0, '1);
    do_read(5, '1, '0, 0, 0);
    do_read(5, '0, '0, 0, 0);
    chk("row5_all_ones", 64'(model_read(5, '0, '0)), 64'(16'hFFFF));
    do_prog(7, COLS'(16'h0008), '1, '1);
    do_read(7, '0, COLS'(16'h0008), 0, 0);
    do_read(7, '0, '0, 0, 0);
    do_read(5, COLS'(16'h5A5A), '0, 10, 1);
    do_read(5, '0, '1, 0, 0);

    // Reset during the second PROG cycle clears the array
    do_prog(9, '1, '0, '1);
    issue(1'b1, 9, '1, '1, '1, '0, '0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst_rsp_dout", 64'(rsp_dout), 64'(0));
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    tick();
    do_read(9, '0, '0, 0, 0);
    do_read(5, '0, '0, 0, 0);

    // Out-of-range row
    do_prog(0, '1, '0, '1);
    do_read(50, '0, '0, 2, 0);
    do_prog(50, '1, '1, '1);
    do_prog(18, COLS'(16'h00FF), '1, '1);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      row  = int'($urandom_range(0, 55));
      en   = COLS'($urandom());
      bl   = COLS'($urandom());
      sl   = COLS'($urandom());
      din  = COLS'($urandom());
      dinb = COLS'($urandom());
      if ($urandom_range(0, 1) == 1) do_prog(row, en, bl, sl);
      else do_read(row, din, dinb, int'($urandom_range(0, 3)), 0);
    end

    // Sweep every row against the model
    do_prog(50, '1, '0, '1);
    for (int r = 0; r < ROWS; r++) begin
      din  = COLS'($urandom());
      dinb = COLS'($urandom());
      do_read(r, din, dinb, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
